// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 6-stage core: stall merging, branch/mret redirects and
// interrupt entry sequencing (flush of all stage registers, trap CSR write, vector to mtvec).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | normal operation, interrupts may be taken
// INT_WAIT  | interrupt accepted, waiting for the in-flight bus transfer
// INT_FLUSH | one cycle: flush all stages, write trap CSRs, jump to mtvec
// INT_HOLD  | one cycle settle after entry, new interrupts not taken
module pipe_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  stallreq_id_in,
    input  logic                  stallreq_exe_in,
    input  logic                  stallreq_mem_in,
    input  logic                  branch_flag_in,
    input  logic [ADDR_WIDTH-1:0] branch_target_in,
    input  logic                  mret_in,
    input  logic [ADDR_WIDTH-1:0] mepc_in,
    input  logic                  irq_in,
    input  logic                  global_ie_in,
    input  logic [ADDR_WIDTH-1:0] mtvec_in,
    input  logic [ADDR_WIDTH-1:0] mem_inst_address_in,
    output logic [5:0]            stall_out,
    output logic                  interrupt_flush_out,
    output logic                  branch_flush_out,
    output logic                  pc_redirect_out,
    output logic [ADDR_WIDTH-1:0] pc_target_out,
    output logic                  trap_we_out,
    output logic [ADDR_WIDTH-1:0] trap_epc_out,
    output logic                  int_busy_out,
    output logic                  timeout_out
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INT_WAIT  = 2'd1,
        INT_FLUSH = 2'd2,
        INT_HOLD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
    logic                    timeout_q, timeout_d;
    logic                    take;

    // A bubble in MEM has no valid PC to return to, so entry is deferred until one arrives.
    assign take = irq_in & global_ie_in & (mem_inst_address_in != '0);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            epc_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    epc_d   = mem_inst_address_in;
                    cnt_d   = '0;
                    state_d = stallreq_mem_in ? INT_WAIT : INT_FLUSH;
                end
            end
            INT_WAIT: begin
                // A bus transfer is never aborted; the timeout only flags the long wait.
                if (stallreq_mem_in) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_MAX) timeout_d = 1'b1;
                end else begin
                    state_d = INT_FLUSH;
                end
            end
            INT_FLUSH: state_d = INT_HOLD;
            INT_HOLD:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_out           = 6'b000000;
        interrupt_flush_out = 1'b0;
        branch_flush_out    = 1'b0;
        pc_redirect_out     = 1'b0;
        pc_target_out       = '0;
        trap_we_out         = 1'b0;
        trap_epc_out        = '0;
        int_busy_out        = 1'b0;
        timeout_out         = 1'b0;
        // Everything is gated in the reset cycle so a mid-sequence reset emits no trap write.
        if (!reset_in) begin
            int_busy_out = (state_q != IDLE);
            timeout_out  = timeout_q;
            if (state_q == INT_FLUSH) begin
                interrupt_flush_out = 1'b1;
                trap_we_out         = 1'b1;
                trap_epc_out        = epc_q;
                pc_redirect_out     = 1'b1;
                pc_target_out       = mtvec_in;
            end else begin
                if (stallreq_mem_in)      stall_out = 6'b011111;
                else if (stallreq_exe_in) stall_out = 6'b001111;
                else if (stallreq_id_in)  stall_out = 6'b000111;
                if (mret_in) begin
                    pc_redirect_out  = 1'b1;
                    pc_target_out    = mepc_in;
                    branch_flush_out = 1'b1;
                end else if (branch_flag_in) begin
                    pc_redirect_out  = 1'b1;
                    pc_target_out    = branch_target_in;
                    branch_flush_out = 1'b1;
                end
            end
        end
    end

endmodule
